// File: rtl/ew_ram_mr_w_s_init_if.sv
// Bus bundle for ew_ram_mr_w_s_init: one byte-enabled write port, RD_PORTS read ports,
// init sweep control and a debug view of the controller state.
interface ew_ram_mr_w_s_init_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_PORTS   = 2
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                             init_req;
  logic                             init_busy;
  logic                             cs_n;
  logic                             wr_n;
  logic [BE_WIDTH-1:0]              be;
  logic [ADDR_WIDTH-1:0]            wr_addr;
  logic [DATA_WIDTH-1:0]            data_in;
  logic [RD_PORTS-1:0]              rd_en;
  logic [RD_PORTS*ADDR_WIDTH-1:0]   rd_addr;
  logic [RD_PORTS*DATA_WIDTH-1:0]   data_out;
  logic [RD_PORTS-1:0]              rd_valid;
  logic                             state_dbg;  // 0 = INIT sweep, 1 = READY

  // Writes are fire-and-forget (no ready); each read port returns rd_valid as
  // its completion strobe, aligned with data_out on that port.
  modport master (
    output init_req, cs_n, wr_n, be, wr_addr, data_in, rd_en, rd_addr,
    input  init_busy, data_out, rd_valid, state_dbg
  );
  modport slave (
    input  init_req, cs_n, wr_n, be, wr_addr, data_in, rd_en, rd_addr,
    output init_busy, data_out, rd_valid, state_dbg
  );
endinterface

// File: rtl/ew_ram_mr_w_s_init.sv
// Multi-read, single-write register-file RAM cleared by a sequential init sweep.
// Optional macro EW_RAM_RD_BYPASS_EN: write-to-read forwarding when RD_LATENCY=1.
module ew_ram_mr_w_s_init #(
  parameter int DATA_WIDTH = 32,
  parameter int RAM_DEPTH  = 16,
  parameter int RD_PORTS   = 2,
  parameter int RD_LATENCY = 1
) (
  input logic               clk,
  input logic               rst_n,
  ew_ram_mr_w_s_init_if.slave bus
);
  localparam int ADDR_WIDTH = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int BE_WIDTH   = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  init_we;
  logic                  ready;
  logic                  wr_ok;

  // No reset on the array so it can map onto RAM primitives.
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic [ADDR_WIDTH-1:0] rd_a     [RD_PORTS];
  logic [DATA_WIDTH-1:0] rd_word  [RD_PORTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    init_we    = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_we = 1'b1;
        if (init_cnt_q == LAST_ADDR) begin
          state_d    = ST_READY;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        if (bus.init_req) begin
          state_d    = ST_INIT;
          init_cnt_d = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign ready         = (state_q == ST_READY);
  assign bus.init_busy = ~ready;
  assign bus.state_dbg = state_q;
  assign wr_ok = ready && !bus.cs_n && !bus.wr_n && ({1'b0, bus.wr_addr} < DEPTH_W);

  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_cnt_q] <= '0;
    end else if (wr_ok) begin
      for (int k = 0; k < BE_WIDTH; k++) begin
        if (bus.be[k]) mem[bus.wr_addr][8*k +: 8] <= bus.data_in[8*k +: 8];
      end
    end
  end

  // Out-of-range reads return zero rather than whatever the array index yields.
  always_comb begin
    for (int p = 0; p < RD_PORTS; p++) begin
      rd_a[p]    = bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      rd_word[p] = ({1'b0, rd_a[p]} < DEPTH_W) ? mem[rd_a[p]] : '0;
    end
  end

  generate
    if (RD_LATENCY == 0) begin : g_comb_rd
      always_comb begin
        bus.data_out = '0;
        bus.rd_valid = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
          if (ready) bus.data_out[p*DATA_WIDTH +: DATA_WIDTH] = rd_word[p];
          bus.rd_valid[p] = bus.rd_en[p] & ready;
        end
      end
    end else begin : g_reg_rd
      logic [DATA_WIDTH-1:0] fwd_word [RD_PORTS];
      logic [DATA_WIDTH-1:0] dout_q   [RD_PORTS];
      logic [RD_PORTS-1:0]   valid_q;

      always_comb begin
        for (int p = 0; p < RD_PORTS; p++) begin
          fwd_word[p] = rd_word[p];
`ifdef EW_RAM_RD_BYPASS_EN
          // wr_ok already implies the address is in range.
          if (wr_ok && (bus.wr_addr == rd_a[p])) begin
            for (int k = 0; k < BE_WIDTH; k++) begin
              if (bus.be[k]) fwd_word[p][8*k +: 8] = bus.data_in[8*k +: 8];
            end
          end
`endif
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= '0;
          for (int p = 0; p < RD_PORTS; p++) dout_q[p] <= '0;
        end else begin
          valid_q <= bus.rd_en & {RD_PORTS{ready}};
          for (int p = 0; p < RD_PORTS; p++) begin
            if (bus.rd_en[p] && ready) dout_q[p] <= fwd_word[p];
          end
        end
      end

      always_comb begin
        bus.data_out = '0;
        for (int p = 0; p < RD_PORTS; p++) bus.data_out[p*DATA_WIDTH +: DATA_WIDTH] = dout_q[p];
        bus.rd_valid = valid_q;
      end
    end
  endgenerate
endmodule

// File: tb/tb_ew_ram_mr_w_s_init.sv
// Directed bench for ew_ram_mr_w_s_init: RAM_DEPTH=16 main instance plus a RAM_DEPTH=12 instance,
// both RD_LATENCY=1; expectations follow EW_RAM_RD_BYPASS_EN when defined.
module tb_ew_ram_mr_w_s_init;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  ew_ram_mr_w_s_init_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_PORTS(2)) bus ();
  ew_ram_mr_w_s_init_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_PORTS(2)) bus12 ();

  ew_ram_mr_w_s_init #(.DATA_WIDTH(32), .RAM_DEPTH(16), .RD_PORTS(2), .RD_LATENCY(1))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  ew_ram_mr_w_s_init #(.DATA_WIDTH(32), .RAM_DEPTH(12), .RD_PORTS(2), .RD_LATENCY(1))
    dut12 (.clk(clk), .rst_n(rst_n), .bus(bus12));

  typedef struct {
    logic        cs_n, wr_n;
    logic [3:0]  be, wa;
    logic [31:0] wd;
    logic [1:0]  en;
    logic [3:0]  a0, a1;
    logic [1:0]  ev;
    logic [31:0] ed0, ed1;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cs_n, input logic wr_n, input logic [3:0] be, input logic [3:0] wa,
                       input logic [31:0] wd, input logic [1:0] en, input logic [3:0] a0, input logic [3:0] a1);
    bus.cs_n    = cs_n;
    bus.wr_n    = wr_n;
    bus.be      = be;
    bus.wr_addr = wa;
    bus.data_in = wd;
    bus.rd_en   = en;
    bus.rd_addr = {a1, a0};
  endtask

  task automatic drive12(input logic cs_n, input logic wr_n, input logic [3:0] wa, input logic [31:0] wd,
                         input logic [1:0] en, input logic [3:0] a0, input logic [3:0] a1);
    bus12.cs_n    = cs_n;
    bus12.wr_n    = wr_n;
    bus12.be      = 4'hF;
    bus12.wr_addr = wa;
    bus12.data_in = wd;
    bus12.rd_en   = en;
    bus12.rd_addr = {a1, a0};
  endtask

  task automatic idle();
    bus.init_req = 1'b0;
    drive(1'b1, 1'b1, 4'h0, 4'h0, 32'h0, 2'b00, 4'h0, 4'h0);
    bus12.init_req = 1'b0;
    drive12(1'b1, 1'b1, 4'h0, 32'h0, 2'b00, 4'h0, 4'h0);
  endtask

  // Reads every address on both ports (port 1 walks backwards) and expects val everywhere.
  task automatic read_all_check(input string name, input logic [31:0] val);
    logic [31:0] e;
    for (int a = 0; a < 16; a++) begin
      exp_q.push_back(val);
      exp_q.push_back(val);
      drive(1'b1, 1'b1, 4'h0, 4'h0, 32'h0, 2'b11, 4'(a), 4'(15 - a));
      step();
      check({name, "_valid"}, 64'(bus.rd_valid), 64'(2'b11));
      e = exp_q.pop_front();
      check({name, "_d0"}, 64'(bus.data_out[31:0]), 64'(e));
      e = exp_q.pop_front();
      check({name, "_d1"}, 64'(bus.data_out[63:32]), 64'(e));
    end
    idle();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"},  64'(bus.init_busy), 64'(1'b1));
    check({name, "_state"}, 64'(bus.state_dbg), 64'(1'b0));
    check({name, "_valid"}, 64'(bus.rd_valid),  64'(2'b00));
    check({name, "_dout"},  64'(bus.data_out),  64'h0);
    check({name, "_busy12"}, 64'(bus12.init_busy), 64'(1'b1));
  endtask

  // Counts edges until each instance leaves INIT, bounded at 100.
  task automatic count_sweep(input string name);
    int n = 0, n16 = 0, n12 = 0;
    while ((bus.init_busy || bus12.init_busy) && n < 100) begin
      step();
      n++;
      if (!bus.init_busy && n16 == 0) n16 = n;
      if (!bus12.init_busy && n12 == 0) n12 = n;
    end
    check({name, "_len16"}, 64'(n16), 64'd16);
    check({name, "_len12"}, 64'(n12), 64'd12);
  endtask

  logic [31:0] byp_new;

  initial begin
`ifdef EW_RAM_RD_BYPASS_EN
    byp_new = 32'hCAFEF00D;
`else
    byp_new = 32'h00000000;
`endif
    //              cs wr be    wa    wd            en     a0    a1    ev     ed0           ed1
    vecs[0] = '{1'b0, 1'b0, 4'hF, 4'h3, 32'hDEADBEEF, 2'b00, 4'h0, 4'h0, 2'b00, 32'h0,        32'h0};
    vecs[1] = '{1'b0, 1'b0, 4'h5, 4'h3, 32'h11223344, 2'b00, 4'h0, 4'h0, 2'b00, 32'h0,        32'h0};
    vecs[2] = '{1'b1, 1'b1, 4'h0, 4'h0, 32'h0,        2'b10, 4'h0, 4'h3, 2'b10, 32'h0,        32'hDE22BE44};
    vecs[3] = '{1'b0, 1'b0, 4'h0, 4'h3, 32'hFFFFFFFF, 2'b01, 4'h3, 4'h0, 2'b01, 32'hDE22BE44, 32'hDE22BE44};
    vecs[4] = '{1'b1, 1'b0, 4'hF, 4'h4, 32'h12345678, 2'b00, 4'h0, 4'h0, 2'b00, 32'hDE22BE44, 32'hDE22BE44};
    vecs[5] = '{1'b0, 1'b1, 4'hF, 4'h4, 32'h12345678, 2'b00, 4'h0, 4'h0, 2'b00, 32'hDE22BE44, 32'hDE22BE44};
    vecs[6] = '{1'b1, 1'b1, 4'h0, 4'h0, 32'h0,        2'b11, 4'h4, 4'h3, 2'b11, 32'h0,        32'hDE22BE44};
    vecs[7] = '{1'b0, 1'b0, 4'hF, 4'h5, 32'hCAFEF00D, 2'b11, 4'h5, 4'h5, 2'b11, byp_new,      byp_new};
    vecs[8] = '{1'b1, 1'b1, 4'h0, 4'h0, 32'h0,        2'b11, 4'h5, 4'h5, 2'b11, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[9] = '{1'b1, 1'b1, 4'h0, 4'h0, 32'h0,        2'b00, 4'h0, 4'h0, 2'b00, 32'hCAFEF00D, 32'hCAFEF00D};

    // Clock/reset
    idle();
    rst_n = 1'b1;
    #3;
    rst_n = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    count_sweep("sweep0");

    read_all_check("clear0", 32'h0);

    // Write/read vector table
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].cs_n, vecs[i].wr_n, vecs[i].be, vecs[i].wa, vecs[i].wd,
            vecs[i].en, vecs[i].a0, vecs[i].a1);
      step();
      check($sformatf("vec%0d_valid", i), 64'(bus.rd_valid), 64'(vecs[i].ev));
      check($sformatf("vec%0d_d0", i), 64'(bus.data_out[31:0]), 64'(vecs[i].ed0));
      check($sformatf("vec%0d_d1", i), 64'(bus.data_out[63:32]), 64'(vecs[i].ed1));
    end
    idle();

    // Fill, then re-init from READY with writes and reads attempted during the sweep
    for (int a = 0; a < 16; a++) begin
      drive(1'b0, 1'b0, 4'hF, 4'(a), 32'hA5A5A5A5, 2'b00, 4'h0, 4'h0);
      step();
    end
    read_all_check("fill", 32'hA5A5A5A5);
    bus.init_req = 1'b1;
    step();
    check("init_req_busy", 64'(bus.init_busy), 64'(1'b1));
    begin
      int n = 0;
      while (bus.init_busy && n < 100) begin
        if (n == 3) bus.init_req = 1'b0;
        drive(1'b0, 1'b0, 4'hF, 4'h0, 32'hFFFFFFFF, 2'b11, 4'h0, 4'h1);
        step();
        n++;
        check("init_win_valid", 64'(bus.rd_valid), 64'(2'b00));
        check("init_win_hold", 64'(bus.data_out), 64'hA5A5A5A5_A5A5A5A5);
      end
      check("init_req_len", 64'(n), 64'd16);
    end
    idle();
    read_all_check("clear1", 32'h0);

    // Reset asserted mid-sweep at init_cnt=7
    drive(1'b0, 1'b0, 4'hF, 4'h2, 32'h0BADF00D, 2'b00, 4'h0, 4'h0);
    step();
    drive(1'b1, 1'b1, 4'h0, 4'h0, 32'h0, 2'b01, 4'h2, 4'h0);
    step();
    check("pre_rst_d0", 64'(bus.data_out[31:0]), 64'h0BADF00D);
    idle();
    bus.init_req = 1'b1;
    step();
    bus.init_req = 1'b0;
    repeat (7) step();
    check("mid_sweep_busy", 64'(bus.init_busy), 64'(1'b1));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    step();
    rst_n = 1'b1;
    count_sweep("sweep1");
    read_all_check("clear2", 32'h0);

    // RAM_DEPTH=12 instance: out-of-range write discarded, out-of-range read returns 0
    drive12(1'b0, 1'b0, 4'd13, 32'hFFFFFFFF, 2'b00, 4'h0, 4'h0);
    step();
    drive12(1'b0, 1'b0, 4'd11, 32'h12345678, 2'b00, 4'h0, 4'h0);
    step();
    drive12(1'b1, 1'b1, 4'd0, 32'h0, 2'b11, 4'd13, 4'd11);
    step();
    check("d12_oor_valid", 64'(bus12.rd_valid), 64'(2'b11));
    check("d12_oor_d0", 64'(bus12.data_out[31:0]), 64'h0);
    check("d12_a11_d1", 64'(bus12.data_out[63:32]), 64'h12345678);
    for (int a = 0; a < 11; a++) begin
      drive12(1'b1, 1'b1, 4'd0, 32'h0, 2'b11, 4'(a), 4'(10 - a));
      step();
      check($sformatf("d12_rd%0d_valid", a), 64'(bus12.rd_valid), 64'(2'b11));
      check($sformatf("d12_rd%0d", a), 64'(bus12.data_out), 64'h0);
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ew_ram_mr_w_s_init.md
# ew_ram_mr_w_s_init

Parametrised successor to the single-port-write register-file RAM. Provides one byte-enabled write port and RD_PORTS independent read ports. Read latency is selectable: 0 for combinational, 1 for registered. Memory clearing is done by a sequential init sweep instead of a parallel reset, so the array carries no reset and synthesis can map it to RAM. Used as the storage core for multi-reader FIFOs and descriptor tables.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; must be a multiple of 8
- RAM_DEPTH, 16, number of words; need not be a power of 2
- RD_PORTS, 2, number of read ports, 1..8
- RD_LATENCY, 1, 0 = combinational read, 1 = registered read
- ADDR_WIDTH (local), $clog2(RAM_DEPTH); BE_WIDTH (local), DATA_WIDTH/8

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- init_req  in  1  restart the clear sweep; level, sampled when idle
- init_busy  out  1  clear sweep in progress
- cs_n  in  1  write chip select, active-low
- wr_n  in  1  write enable, active-low
- be  in  BE_WIDTH  byte enables; bit k controls data_in[8k+7:8k]
- wr_addr  in  ADDR_WIDTH  write address
- data_in  in  DATA_WIDTH  write data
- rd_en  in  RD_PORTS  per-port read enable
- rd_addr  in  RD_PORTS*ADDR_WIDTH  port p uses slice [p*ADDR_WIDTH +: ADDR_WIDTH]
- data_out  out  RD_PORTS*DATA_WIDTH  port p uses slice [p*DATA_WIDTH +: DATA_WIDTH]
- rd_valid  out  RD_PORTS  per-port data-valid

## Operation
- FSM states: INIT and READY. Asynchronous rst_n forces INIT with init_cnt=0. The array itself has no reset.
- INIT:
  - Each clock edge writes 0 to mem[init_cnt] and increments init_cnt.
  - When init_cnt==RAM_DEPTH-1 is written, the FSM moves to READY.
  - init_req is ignored in INIT.
- READY: init_req=1 at an edge returns the FSM to INIT with init_cnt=0.
- Writes:
  - Condition: READY & ~cs_n & ~wr_n.
  - Only the bytes with be[k]=1 are updated; be=0 performs no write.
  - A write with wr_addr>=RAM_DEPTH is discarded.
  - Writes in INIT are discarded without error.
- Reads:
  - A read on port p is accepted when rd_en[p] & READY.
  - A read with address >=RAM_DEPTH returns 0 and still asserts rd_valid.
  - Reads in INIT are dropped: rd_valid[p]=0 and data_out is unchanged (RD_LATENCY=1) or 0 (RD_LATENCY=0).
- All ports may read the same address in the same cycle. A write may coincide with any reads.

## Timing
- Reset values: init_busy=1, rd_valid=0, registered data_out=0, FSM=INIT, init_cnt=0.
- The init sweep takes RAM_DEPTH cycles. init_busy drops after the RAM_DEPTH-th rising edge following rst_n release or init_req acceptance.
- init_busy=1 on the cycle after init_req is accepted.
- RD_LATENCY=0:
  - data_out[p] = mem[rd_addr[p]] combinationally.
  - rd_valid[p] = rd_en[p] & ~init_busy.
  - A write to the same address is visible only after the write edge.
- RD_LATENCY=1:
  - rd_en at edge N gives data_out and rd_valid at edge N+1.
  - rd_valid is a single-cycle pulse per accepted read.
  - data_out holds its last value when no read is accepted.
- Write latency: 1 edge.
- A reset assertion mid-sweep or mid-read aborts immediately: outputs go to reset values and the sweep restarts from 0.

## Configuration
- EW_RAM_RD_BYPASS_EN controls read-during-write forwarding when RD_LATENCY=1.
  - Defined: a same-cycle write and read to the same in-range address returns the byte-merged new word. Enabled bytes come from data_in; the others come from the old mem contents.
  - Undefined: the read returns the old word (read-before-write).
- The macro has no effect when RD_LATENCY=0.

## Test plan
- Reset, RAM_DEPTH=16: init_busy=1 for exactly 16 edges after rst_n release. Every address then reads 0x00000000 with rd_valid=1 one cycle after rd_en.
- Write 0xDEADBEEF to addr 3 with be=4'b1111, then be=4'b0101 with data 0x11223344. Port 1 then reads 0xDE22BE44.
- Same cycle: write 0xCAFEF00D to addr 5 and read addr 5 on ports 0 and 1 (RD_LATENCY=1). With the macro, both ports return 0xCAFEF00D. Without it, both return the prior value 0x00000000.
- RAM_DEPTH=12: write addr 13. A read of addr 13 returns 0 with rd_valid=1, and addrs 0..11 are unchanged.
- Assert init_req in READY after filling all words with 0xA5A5A5A5. init_busy goes high for 16 cycles and writes and reads in that window are dropped; afterwards every word reads 0.
- Drop rst_n for 1 cycle mid-sweep at init_cnt=7. Outputs go to reset values immediately, and the full 16-cycle sweep reruns after release.
